// File: rtl/tea_arbiter_if.sv
// Requester/core-side signal bundle for the two-requester TEA arbiter.
// The slave modport is the arbiter's view; master is the requester/core side.
interface tea_arbiter_if;
  logic         req0, req1;
  logic [127:0] key0, key1;
  logic [31:0]  v0_0, v1_0, v0_1, v1_1;
  logic [31:0]  cfg_delta;
  logic         gnt0, gnt1;
  logic         rsp_valid0, rsp_valid1;
  logic [31:0]  rsp_v0, rsp_v1;
  logic         rsp_err;
  logic         busy;
  logic         core_start;
  logic [31:0]  core_delta, core_k0, core_k1, core_k2, core_k3, core_v0, core_v1;
  logic         core_done;
  logic [31:0]  core_enc_v0, core_enc_v1;

  modport slave (
    input  req0, req1, key0, key1, v0_0, v1_0, v0_1, v1_1, cfg_delta,
    input  core_done, core_enc_v0, core_enc_v1,
    output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_v0, rsp_v1, rsp_err, busy,
    output core_start, core_delta, core_k0, core_k1, core_k2, core_k3, core_v0, core_v1
  );

  modport master (
    output req0, req1, key0, key1, v0_0, v1_0, v0_1, v1_1, cfg_delta,
    output core_done, core_enc_v0, core_enc_v1,
    input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_v0, rsp_v1, rsp_err, busy,
    input  core_start, core_delta, core_k0, core_k1, core_k2, core_k3, core_v0, core_v1
  );
endinterface

// File: rtl/tea_arbiter.sv
// Round-robin arbiter feeding one TEA core from two requesters; one request
// in flight, with a per-request completion timeout.
module tea_arbiter #(
  parameter int unsigned TIMEOUT = 1000
) (
  input logic        clk,
  input logic        rst_n,
  tea_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t       state_q, state_d;
  logic         last_q, last_d;
  logic         owner_q, owner_d;
  logic [1:0]   gnt_q, gnt_d;
  logic         start_q, start_d;
  logic [1:0]   vld_q, vld_d;
  logic [31:0]  rsp_v0_q, rsp_v0_d, rsp_v1_q, rsp_v1_d;
  logic         err_q, err_d;
  logic [31:0]  delta_q, delta_d;
  logic [127:0] key_q, key_d;
  logic [31:0]  v0_q, v0_d, v1_q, v1_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         prev_done_q;
  logic         done_edge;
  logic         win;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    gnt_d    = '0;
    start_d  = 1'b0;
    vld_d    = '0;
    rsp_v0_d = rsp_v0_q;
    rsp_v1_d = rsp_v1_q;
    err_d    = err_q;
    delta_d  = delta_q;
    key_d    = key_q;
    v0_d     = v0_q;
    v1_d     = v1_q;
    cnt_d    = cnt_q;
    done_edge = bus.core_done & ~prev_done_q;
    // On a tie the requester that was not served last wins.
    win = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

    case (state_q)
      IDLE: if (bus.req0 | bus.req1) begin
        owner_d    = win;
        last_d     = win;
        key_d      = win ? bus.key1 : bus.key0;
        v0_d       = win ? bus.v0_1 : bus.v0_0;
        v1_d       = win ? bus.v1_1 : bus.v1_0;
        delta_d    = bus.cfg_delta;
        gnt_d[win] = 1'b1;
        start_d    = 1'b1;
        state_d    = ISSUE;
      end
      ISSUE: begin
        cnt_d   = TMO;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion in the last allowed cycle still counts as success.
        if (done_edge) begin
          rsp_v0_d       = bus.core_enc_v0;
          rsp_v1_d       = bus.core_enc_v1;
          err_d          = 1'b0;
          vld_d[owner_q] = 1'b1;
          state_d        = RESP;
        end else if (cnt_q == 16'd1) begin
          rsp_v0_d       = '0;
          rsp_v1_d       = '0;
          err_d          = 1'b1;
          vld_d[owner_q] = 1'b1;
          state_d        = RESP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      gnt_q       <= '0;
      start_q     <= 1'b0;
      vld_q       <= '0;
      rsp_v0_q    <= '0;
      rsp_v1_q    <= '0;
      err_q       <= 1'b0;
      delta_q     <= '0;
      key_q       <= '0;
      v0_q        <= '0;
      v1_q        <= '0;
      cnt_q       <= '0;
      prev_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      start_q     <= start_d;
      vld_q       <= vld_d;
      rsp_v0_q    <= rsp_v0_d;
      rsp_v1_q    <= rsp_v1_d;
      err_q       <= err_d;
      delta_q     <= delta_d;
      key_q       <= key_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      cnt_q       <= cnt_d;
      prev_done_q <= bus.core_done;
    end
  end

  assign bus.gnt0       = gnt_q[0];
  assign bus.gnt1       = gnt_q[1];
  assign bus.core_start = start_q;
  assign bus.rsp_valid0 = vld_q[0];
  assign bus.rsp_valid1 = vld_q[1];
  assign bus.rsp_v0     = rsp_v0_q;
  assign bus.rsp_v1     = rsp_v1_q;
  assign bus.rsp_err    = err_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.core_delta = delta_q;
  assign bus.core_k0    = key_q[127:96];
  assign bus.core_k1    = key_q[95:64];
  assign bus.core_k2    = key_q[63:32];
  assign bus.core_k3    = key_q[31:0];
  assign bus.core_v0    = v0_q;
  assign bus.core_v1    = v1_q;
endmodule

// File: tb/tb_tea_arbiter.sv
// Directed bench for tea_arbiter: queued expected responses checked by a
// separate monitor, plus in-line timing checks on grants and pulses.
module tb_tea_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tea_arbiter_if bus();
  tea_arbiter #(.TIMEOUT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int          who;
    logic [31:0] v0;
    logic [31:0] v1;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [63:0] tea(logic [127:0] k, logic [31:0] d, logic [31:0] a, logic [31:0] b);
    logic [31:0] s, y, z;
    s = 0; y = a; z = b;
    for (int i = 0; i < 32; i++) begin
      s = s + d;
      y = y + ((((z << 4) + k[127:96]) ^ (z + s)) ^ ((z >> 5) + k[95:64]));
      z = z + ((((y << 4) + k[63:32]) ^ (y + s)) ^ ((y >> 5) + k[31:0]));
    end
    return {y, z};
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Expected result from the stimulus currently on the requester inputs
  task automatic push_exp(int who, bit err);
    logic [63:0] r;
    exp_t e;
    r = (who == 1) ? tea(bus.key1, bus.cfg_delta, bus.v0_1, bus.v1_1)
                   : tea(bus.key0, bus.cfg_delta, bus.v0_0, bus.v1_0);
    e.who = who;
    e.v0  = err ? 32'h0 : r[63:32];
    e.v1  = err ? 32'h0 : r[31:0];
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.gnt0 || bus.gnt1) begin
        who = bus.gnt1 ? 1 : 0;
        break;
      end
      cyc(1);
    end
  endtask

  // Core model: computes from the arbiter's core_* outputs, called in ISSUE
  task automatic serve(int lat, bit hold);
    logic [63:0] r;
    r = tea({bus.core_k0, bus.core_k1, bus.core_k2, bus.core_k3}, bus.core_delta, bus.core_v0, bus.core_v1);
    cyc(lat);
    bus.core_enc_v0 = r[63:32];
    bus.core_enc_v1 = r[31:0];
    bus.core_done   = 1'b1;
    cyc(1);
    if (!hold) bus.core_done = 1'b0;
  endtask

  task automatic grant_and_serve(int exp_who, int lat, bit hold);
    int who;
    wait_gnt(who);
    chk("grant_winner", who, exp_who);
    if (who == 0) bus.req0 = 1'b0;
    if (who == 1) bus.req1 = 1'b0;
    serve(lat, hold);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus.rsp_valid0 === 1'b1 || bus.rsp_valid1 === 1'b1)) begin
      chk("rsp_one_hot", {bus.rsp_valid1, bus.rsp_valid0} == 2'b11, 0);
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_who", bus.rsp_valid1 ? 1 : 0, e.who);
        chk("rsp_v0", bus.rsp_v0, e.v0);
        chk("rsp_v1", bus.rsp_v1, e.v1);
        chk("rsp_err", bus.rsp_err, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int who;
    logic [63:0] r;
    rst_n = 1'b0;
    bus.req0 = 0; bus.req1 = 0;
    bus.key0 = {32'd5, 32'd4, 32'd3, 32'd7};
    bus.key1 = {32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
    bus.v0_0 = 32'd13; bus.v1_0 = 32'd17;
    bus.v0_1 = 32'hdeadbeef; bus.v1_1 = 32'h0badf00d;
    bus.cfg_delta = 32'd10;
    bus.core_done = 0; bus.core_enc_v0 = 0; bus.core_enc_v1 = 0;
    cyc(2);
    chk("rst_busy", bus.busy, 0);
    chk("rst_gnt", {bus.gnt1, bus.gnt0}, 0);
    chk("rst_rsp_valid", {bus.rsp_valid1, bus.rsp_valid0}, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_core_regs", {bus.core_delta, bus.core_k0, bus.core_v0, bus.core_v1}, 0);
    chk("rst_rsp", {bus.rsp_err, bus.rsp_v0, bus.rsp_v1}, 0);
    rst_n = 1'b1;
    cyc(1);

    // Single request with the reference vector
    r = tea(bus.key0, 32'd10, 32'd13, 32'd17);
    push_exp(0, 0);
    bus.req0 = 1;
    cyc(1);
    chk("t1_gnt0", {bus.gnt1, bus.gnt0}, 2'b01);
    chk("t1_core_start", bus.core_start, 1);
    chk("t1_core_delta", bus.core_delta, 32'd10);
    chk("t1_core_key", {bus.core_k0, bus.core_k1, bus.core_k2, bus.core_k3}, {32'd5, 32'd4, 32'd3, 32'd7});
    chk("t1_core_v", {bus.core_v0, bus.core_v1}, {32'd13, 32'd17});
    chk("t1_busy", bus.busy, 1);
    bus.req0 = 0;
    serve(1, 0);
    chk("t1_rsp_latency", bus.rsp_valid0, 1);
    cyc(1);
    chk("t1_gnt_pulse", {bus.gnt0, bus.core_start, bus.rsp_valid0}, 0);
    chk("t1_idle", bus.busy, 0);
    cyc(2);
    chk("t1_rsp_hold", {bus.rsp_v0, bus.rsp_v1}, r);

    // Ties alternate, starting with requester 0 after reset
    rst_n = 0; cyc(1); rst_n = 1;
    bus.req0 = 1; bus.req1 = 1;
    push_exp(0, 0);
    grant_and_serve(0, 2, 0);
    bus.req0 = 1;
    push_exp(1, 0);
    push_exp(0, 0);
    grant_and_serve(1, 2, 0);
    grant_and_serve(0, 1, 0);
    cyc(2);

    // Timeout: core never completes, late done ignored
    push_exp(0, 1);
    bus.req0 = 1;
    cyc(1);
    wait_gnt(who);
    chk("t3_gnt", who, 0);
    bus.req0 = 0;
    cyc(8);
    chk("t3_wait8_busy", {bus.busy, bus.rsp_valid0}, 2'b10);
    cyc(1);
    chk("t3_timeout_rsp", {bus.rsp_valid0, bus.rsp_err}, 2'b11);
    cyc(3);
    bus.core_done = 1;
    cyc(3);
    chk("t3_late_done", {bus.busy, bus.rsp_valid0, bus.rsp_valid1}, 0);
    bus.core_done = 0;
    cyc(1);

    // Done edge in the final WAIT cycle wins over the timeout
    bus.cfg_delta = 32'h9e3779b9;
    push_exp(0, 0);
    bus.req0 = 1;
    cyc(1);
    grant_and_serve(0, 8, 0);
    chk("t4_boundary_rsp", {bus.rsp_valid0, bus.rsp_err}, 2'b10);
    cyc(2);

    // Reset during WAIT aborts silently; next request is served normally
    bus.req0 = 1;
    cyc(1);
    wait_gnt(who);
    bus.req0 = 0;
    cyc(2);
    rst_n = 0; cyc(1); rst_n = 1;
    chk("t5_busy_after_rst", bus.busy, 0);
    bus.core_done = 1;
    cyc(3);
    chk("t5_done_ignored", {bus.busy, bus.rsp_valid0, bus.rsp_valid1}, 0);
    bus.core_done = 0;
    push_exp(1, 0);
    bus.req1 = 1;
    cyc(1);
    grant_and_serve(1, 3, 0);
    cyc(2);

    // Done held high from the previous operation must not complete the next
    push_exp(1, 0);
    bus.req1 = 1;
    cyc(1);
    grant_and_serve(1, 2, 1);
    push_exp(0, 0);
    bus.req0 = 1;
    cyc(1);
    wait_gnt(who);
    chk("t6_gnt", who, 0);
    bus.req0 = 0;
    r = tea({bus.core_k0, bus.core_k1, bus.core_k2, bus.core_k3}, bus.core_delta, bus.core_v0, bus.core_v1);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t6_no_false_done", {bus.busy, bus.rsp_valid0}, 2'b10);
    end
    bus.core_done = 0;
    cyc(1);
    bus.core_enc_v0 = r[63:32];
    bus.core_enc_v1 = r[31:0];
    bus.core_done = 1;
    cyc(1);
    chk("t6_rsp", bus.rsp_valid0, 1);
    bus.core_done = 0;
    cyc(3);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tea_arbiter.md
TEA_ARBITER -- requirements
Module: tea_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1000: max cycles in WAIT before a request is aborted with error; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 cfg_delta  input  32  TEA delta constant, shared by both requesters, sampled at grant.
REQ-005 req0 / req1  input  1  request from requester 0 / 1, level, held until granted.
REQ-006 key0 / key1  input  128  key {k0,k1,k2,k3}, k0 in bits [127:96], for requester 0 / 1.
REQ-007 v0_0, v1_0 / v0_1, v1_1  input  32 each  plaintext words for requester 0 / 1.
REQ-008 gnt0 / gnt1  output  1  one-cycle grant pulse; operands captured.
REQ-009 rsp_valid0 / rsp_valid1  output  1  one-cycle response pulse to requester 0 / 1.
REQ-010 rsp_v0, rsp_v1  output  32 each  result words, shared bus, valid only with an rsp_valid pulse.
REQ-011 rsp_err  output  1  timeout flag, valid only with an rsp_valid pulse.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 core_start  output  1  one-cycle start pulse to the TEA core.
REQ-014 core_delta, core_k0..core_k3, core_v0, core_v1  output  32 each  registered operands to the core, stable from core_start until return to IDLE.
REQ-015 core_done  input  1  core completion level; a rising edge marks completion.
REQ-016 core_enc_v0, core_enc_v1  input  32 each  core ciphertext, valid when core_done is high.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; exactly one request in flight at a time.
REQ-018 IDLE: if any req is high at an edge, the block selects a winner, latches its key/v0/v1 and cfg_delta into the core_* registers, and moves to ISSUE; otherwise it stays in IDLE.
REQ-019 Arbitration: round-robin; pointer last = index of the last granted requester; both requesting -> grant the requester != last; single request -> grant it regardless of pointer; pointer updates on grant.
REQ-020 ISSUE (one cycle): gntX = 1 for the winner and core_start = 1; timeout counter (16 bits) loaded with TIMEOUT; next state WAIT.
REQ-021 Latency: req sampled in IDLE at edge t -> gnt and core_start high in cycle t+1.
REQ-022 A req dropped before its sampling edge is not granted; req is ignored in every state except IDLE.
REQ-023 Done detection: registered prev_done; edge = core_done & ~prev_done; prev_done updates every cycle in all states.
REQ-024 WAIT: on a done edge, capture core_enc_v0/v1 into rsp_v0/v1, clear err, go to RESP; otherwise decrement the counter; if the counter equals 1 and no edge, set err, hold rsp_v0/v1 at 0, go to RESP.
REQ-025 A done edge in the same cycle the counter expires is treated as success (done wins).
REQ-026 RESP (one cycle): rsp_validX = 1 for the granted requester only, with rsp_v0/v1/err driven; next state IDLE.
REQ-027 Done edges outside WAIT, including late completions after a timeout, are ignored and produce no response.
REQ-028 Minimum request-to-response time is 4 cycles (IDLE sample, ISSUE, WAIT with done, RESP); back-to-back throughput is one request per (core latency + 3) cycles.
REQ-029 rsp_v0/rsp_v1/rsp_err hold their value until the next RESP.

Reset
REQ-030 With rst_n = 0 at an edge: state = IDLE, last = 1 (requester 0 wins the first tie); all outputs, core_* registers, counter and prev_done = 0.
REQ-031 Reset asserted mid-operation aborts the request with no rsp_valid; a core_done edge arriving after reset is ignored.

Verification
REQ-032 Single request: req0 = 1, cfg_delta = 10, key0 = {5,4,3,7}, v0_0 = 13, v1_0 = 17 -> gnt0 pulse 1 cycle later, core_* carry these values, one rsp_valid0 with rsp_v0/v1 equal to the reference TEA model output, err = 0.
REQ-033 Tie after reset: req0 and req1 both high -> gnt0 first; req1 stays high -> gnt1 on the next IDLE; then both high again -> gnt0 (alternation).
REQ-034 Timeout: TIMEOUT = 8, core never raises done -> rsp_valid0 with rsp_err = 1 and rsp_v0/v1 = 0 exactly 8 WAIT cycles after ISSUE; a done edge injected 3 cycles later produces no response.
REQ-035 Boundary: done edge in the final WAIT cycle with TIMEOUT = 8 -> err = 0, captured data returned.
REQ-036 Reset mid-WAIT: rst_n low for 1 cycle during WAIT -> busy = 0, no rsp_valid, the next core_done edge is ignored, and the next req1 is granted normally.
REQ-037 Done held high from the previous operation into the next ISSUE -> no false completion; only the next rising edge completes the request.
